// File: rtl/tipi_link_master.sv
// TIPI CPLD serial register link master (RPi side).
// Converts one parallel request into a 9-edge r_clk shift transaction.
module tipi_link_master #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rt,
    input  logic       req_cd,
    input  logic [0:7] req_data,
    output logic       rsp_valid,
    output logic [0:7] rsp_data,
    output logic       rsp_abort,
    output logic       busy,
    output logic       r_clk,
    output logic       r_rt,
    output logic       r_cd,
    output logic       r_le,
    output logic       r_dout,
    input  logic       r_din,
    input  logic       r_reset
);

    generate
        if (CLK_DIV < 3 || CLK_DIV > 255) begin : g_bad_div
            $error("tipi_link_master: CLK_DIV must be 3..255");
        end
    endgenerate

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SETUP = 3'd1;
    localparam logic [2:0] HI    = 3'd2;
    localparam logic [2:0] LO    = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;
    localparam logic [2:0] ABORT = 3'd5;

    localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

    logic [2:0] state;
    logic [7:0] cnt;
    logic [3:0] ecnt;
    logic       rt_q;
    logic [0:7] data_q;
    logic [0:6] rd_buf;
    logic       live;
    logic       din_q1;
    logic       din_s;
    logic       rst_q1;
    logic       rst_s;
    logic       phase_end;
    logic       in_xfer;

    // Link levels presented for edge e (e = 10 means "after the last edge").
    function automatic logic le_for(input logic rt, input logic [3:0] e);
        return rt ? (e == 4'd1) : (e == 4'd9);
    endfunction

    function automatic logic dout_for(input logic rt, input logic [0:7] d,
                                      input logic [3:0] e);
        return !rt && e >= 4'd1 && e <= 4'd8 && d[3'(e - 4'd1)];
    endfunction

    assign phase_end = (cnt == LAST);
    assign in_xfer   = (state == SETUP) || (state == HI) || (state == LO);
    assign busy      = (state != IDLE);
    assign req_ready = live && (state == IDLE) && !rst_s;
    assign rsp_valid = (state == DONE) || (state == ABORT);
    assign rsp_abort = (state == ABORT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            ecnt     <= '0;
            rt_q     <= 1'b0;
            data_q   <= '0;
            rd_buf   <= '0;
            rsp_data <= '0;
            live     <= 1'b0;
            din_q1   <= 1'b0;
            din_s    <= 1'b0;
            rst_q1   <= 1'b0;
            rst_s    <= 1'b0;
            r_clk    <= 1'b0;
            r_rt     <= 1'b0;
            r_cd     <= 1'b0;
            r_le     <= 1'b0;
            r_dout   <= 1'b0;
        end else begin
            live   <= 1'b1;
            din_q1 <= r_din;
            din_s  <= din_q1;
            rst_q1 <= r_reset;
            rst_s  <= rst_q1;
            if (in_xfer && rst_s) begin
                // TI link reset wins over everything, including a high r_clk.
                state    <= ABORT;
                r_clk    <= 1'b0;
                r_le     <= 1'b0;
                r_dout   <= 1'b0;
                r_rt     <= 1'b0;
                r_cd     <= 1'b0;
                rsp_data <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (req_valid && req_ready) begin
                            state  <= SETUP;
                            cnt    <= '0;
                            ecnt   <= 4'd1;
                            rt_q   <= req_rt;
                            data_q <= req_data;
                            r_rt   <= req_rt;
                            r_cd   <= req_cd;
                            r_le   <= le_for(req_rt, 4'd1);
                            r_dout <= dout_for(req_rt, req_data, 4'd1);
                        end
                    end
                    SETUP: begin
                        cnt <= cnt + 8'd1;
                        if (phase_end) begin
                            state <= HI;
                            cnt   <= '0;
                            r_clk <= 1'b1;
                        end
                    end
                    HI: begin
                        cnt <= cnt + 8'd1;
                        if (phase_end) begin
                            state  <= LO;
                            cnt    <= '0;
                            r_clk  <= 1'b0;
                            r_le   <= le_for(rt_q, ecnt + 4'd1);
                            r_dout <= dout_for(rt_q, data_q, ecnt + 4'd1);
                        end
                    end
                    LO: begin
                        cnt <= cnt + 8'd1;
                        if (phase_end) begin
                            cnt <= '0;
                            if (rt_q && ecnt >= 4'd2 && ecnt <= 4'd8)
                                rd_buf[3'(ecnt - 4'd2)] <= din_s;
                            if (ecnt == 4'd9) begin
                                state    <= DONE;
                                rsp_data <= rt_q ? {rd_buf, din_s} : 8'h00;
                                r_le     <= 1'b0;
                                r_dout   <= 1'b0;
                                r_rt     <= 1'b0;
                                r_cd     <= 1'b0;
                            end else begin
                                state <= HI;
                                ecnt  <= ecnt + 4'd1;
                                r_clk <= 1'b1;
                            end
                        end
                    end
                    DONE:    state <= IDLE;
                    ABORT:   state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tipi_link_master.sv
// Scoreboard bench for tipi_link_master with a behavioural CPLD link model.
module tb_tipi_link_master;

    localparam int LAT4 = 1 + 19 * 4;
    localparam int LAT3 = 1 + 19 * 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic       req_rt = 1'b0;
    logic       req_cd = 1'b0;
    logic [0:7] req_data = '0;
    logic       rsp_valid;
    logic [0:7] rsp_data;
    logic       rsp_abort;
    logic       busy;
    logic       r_clk, r_rt, r_cd, r_le, r_dout;
    logic       r_din;
    logic       r_reset = 1'b0;

    logic       req_valid3 = 1'b0;
    logic       req_ready3;
    logic       req_rt3 = 1'b0;
    logic       req_cd3 = 1'b0;
    logic [0:7] req_data3 = '0;
    logic       rsp_valid3;
    logic [0:7] rsp_data3;
    logic       rsp_abort3;
    logic       busy3;
    logic       r_clk3, r_rt3, r_cd3, r_le3, r_dout3;
    logic       r_din3;

    tipi_link_master #(.CLK_DIV(4)) u_dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rt(req_rt), .req_cd(req_cd), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_abort(rsp_abort),
        .busy(busy), .r_clk(r_clk), .r_rt(r_rt), .r_cd(r_cd),
        .r_le(r_le), .r_dout(r_dout), .r_din(r_din), .r_reset(r_reset)
    );

    tipi_link_master #(.CLK_DIV(3)) u_dut3 (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid3), .req_ready(req_ready3),
        .req_rt(req_rt3), .req_cd(req_cd3), .req_data(req_data3),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .rsp_abort(rsp_abort3),
        .busy(busy3), .r_clk(r_clk3), .r_rt(r_rt3), .r_cd(r_cd3),
        .r_le(r_le3), .r_dout(r_dout3), .r_din(r_din3), .r_reset(1'b0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // CPLD model for the CLK_DIV=4 instance
    logic [0:7] td = 8'h3C;
    logic [0:7] tc = 8'hF0;
    logic [0:7] rd = 8'h00;
    logic [0:7] rc = 8'h00;
    logic [0:7] shin = 8'h00;
    logic [0:7] sr = 8'h00;
    logic [2:0] idx = 3'd0;
    logic       din_int = 1'b0;
    assign r_din = din_int;

    always @(posedge r_clk) begin
        if (r_rt) begin
            if (r_le) begin
                sr  <= r_cd ? td : tc;
                idx <= 3'd0;
            end else begin
                din_int <= sr[idx];
                idx     <= idx + 3'd1;
            end
        end else begin
            if (r_le) begin
                if (r_cd) rd <= shin;
                else      rc <= shin;
            end else begin
                shin <= {shin[1:7], r_dout};
            end
        end
    end

    // CPLD model for the CLK_DIV=3 instance, r_din skewed one sys cycle
    logic [0:7] sr3 = 8'h00;
    logic [2:0] idx3 = 3'd0;
    logic       din3_int = 1'b0;
    logic       din3_d = 1'b0;
    assign r_din3 = din3_d;

    always @(posedge r_clk3) begin
        if (r_le3) begin
            sr3  <= 8'h81;
            idx3 <= 3'd0;
        end else begin
            din3_int <= sr3[idx3];
            idx3     <= idx3 + 3'd1;
        end
    end
    always @(posedge clk) din3_d <= din3_int;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [8:0] sbq[$];
    logic [8:0] sbq3[$];

    int         n_acc = 0;
    int         n_rsp = 0;
    int         acc_cyc = 0;
    int         rsp_cyc = 0;
    int         edge_cnt = 0;
    logic [9:1] le_bits = '0;
    logic [0:7] dout_bits = '0;
    logic       rt_seen = 1'b0;
    logic       cd_seen = 1'b0;
    logic       glitch = 1'b0;
    logic       prev_rclk = 1'b0;
    logic [3:0] prev_sig = '0;

    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (req_valid && req_ready) begin
                n_acc++;
                acc_cyc   = cyc;
                edge_cnt  = 0;
                le_bits   = '0;
                dout_bits = '0;
            end
            if (r_clk && !prev_rclk) begin
                edge_cnt++;
                if (edge_cnt <= 9) begin
                    le_bits[edge_cnt] = r_le;
                    if (edge_cnt <= 8) dout_bits[edge_cnt - 1] = r_dout;
                    rt_seen = r_rt;
                    cd_seen = r_cd;
                end
            end
            if (r_clk && prev_rclk && {r_rt, r_cd, r_le, r_dout} != prev_sig)
                glitch = 1'b1;
            if (rsp_valid) begin
                n_rsp++;
                rsp_cyc = cyc;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp: got rsp_valid with empty queue (t=%0t)", $time);
                end else begin
                    e = sbq.pop_front();
                    chk("rsp_abort", rsp_abort, e[8]);
                    chk("rsp_data", rsp_data, e[7:0]);
                    if (!e[8]) chk("latency", cyc - acc_cyc, LAT4);
                end
            end
            prev_rclk = r_clk;
            prev_sig  = {r_rt, r_cd, r_le, r_dout};
        end
    end

    int n_rsp3 = 0;
    int acc3_cyc = 0;

    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (req_valid3 && req_ready3) acc3_cyc = cyc;
            if (rsp_valid3) begin
                n_rsp3++;
                if (sbq3.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_rsp3: got rsp_valid with empty queue (t=%0t)", $time);
                end else begin
                    e = sbq3.pop_front();
                    chk("rsp3_abort", rsp_abort3, e[8]);
                    chk("rsp3_data", rsp_data3, e[7:0]);
                    chk("latency3", cyc - acc3_cyc, LAT3);
                end
            end
        end
    end

    // Caller is at posedge+#1; returns right after the accepting edge.
    task automatic do_req(input logic rt, input logic cd, input logic [0:7] d,
                          input logic hold, input logic push,
                          input logic [8:0] exp);
        int a0;
        a0 = n_acc;
        if (push) sbq.push_back(exp);
        req_valid = 1'b1;
        req_rt    = rt;
        req_cd    = cd;
        req_data  = d;
        for (int i = 0; i < 500 && n_acc == a0; i++) @(posedge clk) #1;
        chk("accept_timeout", n_acc > a0, 1);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 2000 && n_rsp < target; i++) @(posedge clk) #1;
        chk("rsp_timeout", n_rsp >= target, 1);
    endtask

    task automatic wait_edge(input int k);
        for (int i = 0; i < 500 && !(edge_cnt == k && r_clk); i++)
            @(posedge clk) #1;
        chk("edge_timeout", edge_cnt == k && r_clk, 1);
    endtask

    initial begin
        int t_rsp;
        int t_acc;
        #2;
        chk("reset_outs", {r_clk, r_le, r_dout, r_rt, r_cd}, 0);
        chk("reset_rsp", {rsp_valid, rsp_abort, busy, req_ready}, 0);
        chk("reset_rsp_data", rsp_data, 0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk) #1;
        chk("ready_after_reset", req_ready, 1);

        do_req(1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, {1'b0, 8'h00});
        wait_rsp(1);
        chk("a5_dout", dout_bits, 8'hA5);
        chk("a5_le", le_bits, 9'h100);
        chk("a5_rt", rt_seen, 0);
        chk("a5_cd", cd_seen, 1);
        chk("a5_rd", rd, 8'hA5);
        @(posedge clk) #1;
        chk("idle_link", {r_rt, r_cd, r_le, r_dout, r_clk}, 0);

        do_req(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, {1'b0, 8'h3C});
        wait_rsp(2);
        chk("td_le", le_bits, 9'h001);
        chk("td_rt", rt_seen, 1);
        chk("td_cd", cd_seen, 1);

        @(posedge clk) #1;
        do_req(1'b0, 1'b0, 8'h01, 1'b1, 1'b1, {1'b0, 8'h00});
        wait_rsp(3);
        t_rsp = rsp_cyc;
        do_req(1'b1, 1'b0, 8'hF0, 1'b0, 1'b1, {1'b0, 8'hF0});
        t_acc = acc_cyc;
        chk("b2b_gap", t_acc - t_rsp, 1);
        wait_rsp(4);
        chk("rc_value", rc, 8'h01);
        chk("tc_le", le_bits, 9'h001);
        chk("hi_stable", glitch, 0);

        @(posedge clk) #1;
        do_req(1'b1, 1'b1, 8'h00, 1'b0, 1'b1, {1'b1, 8'h00});
        wait_edge(5);
        r_reset = 1'b1;
        for (int i = 0; i < 3 && r_clk; i++) @(posedge clk) #1;
        chk("abort_rclk_low", r_clk, 0);
        wait_rsp(5);
        repeat (4) @(posedge clk) #1;
        chk("abort_ready_low", req_ready, 0);
        chk("abort_idle", busy, 0);
        r_reset = 1'b0;
        repeat (4) @(posedge clk) #1;
        chk("ready_after_rreset", req_ready, 1);

        do_req(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 9'h000);
        wait_edge(3);
        reset_n = 1'b0;
        #1;
        chk("rstn_link", {r_clk, r_le, r_dout, r_rt, r_cd}, 0);
        chk("rstn_ctl", {rsp_valid, rsp_abort, busy, req_ready}, 0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (2) @(posedge clk) #1;
        chk("rstn_no_rsp", n_rsp, 5);

        do_req(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, {1'b0, 8'h00});
        wait_rsp(6);
        chk("5a_dout", dout_bits, 8'h5A);
        chk("5a_rd", rd, 8'h5A);

        sbq3.push_back({1'b0, 8'h81});
        req_valid3 = 1'b1;
        req_rt3    = 1'b1;
        req_cd3    = 1'b0;
        chk("u3_ready", req_ready3, 1);
        @(posedge clk) #1;
        req_valid3 = 1'b0;
        for (int i = 0; i < 500 && n_rsp3 < 1; i++) @(posedge clk) #1;
        chk("rsp3_timeout", n_rsp3 >= 1, 1);

        repeat (3) @(posedge clk) #1;
        chk("sb_empty", sbq.size(), 0);
        chk("sb3_empty", sbq3.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
